// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory/writeback pipeline stages.
package mips_pkg;

  typedef enum logic [2:0] {
    LdLw  = 3'd0,
    LdLh  = 3'd1,
    LdLhu = 3'd2,
    LdLb  = 3'd3,
    LdLbu = 3'd4
  } load_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Big-endian load lane extraction with sign/zero extension and alignment check.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  load_t       ld_type,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = offset[1] ? rdata[15:0] : rdata[31:16];
    unique case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
  end

  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (ld_type)
      LdLh: begin
        data       = {{16{half[15]}}, half};
        misaligned = offset[0];
      end
      LdLhu: begin
        data       = {16'h0000, half};
        misaligned = offset[0];
      end
      LdLb:    data = {{24{byte_sel[7]}}, byte_sel};
      LdLbu:   data = {24'h000000, byte_sel};
      // LW and any unused encoding take the whole word
      default: misaligned = (offset != 2'd0);
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the writeback result, drives the register file
// write port and its forwarding copy, flags misaligned loads and counts retirements.
module mem_wb_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  input  logic        m_reg_write,
  input  logic [4:0]  m_dest,
  input  logic [1:0]  m_wb_sel,
  input  logic [2:0]  m_ld_type,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_mem_rdata,
  input  logic [31:0] m_link,
  input  logic        stall,
  input  logic        flush,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        misalign_exc,
  output logic [31:0] retire_cnt
);

  logic        we_q, we_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic        exc_q, exc_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic        take;
  logic        misaligned;
  logic        ld_misaligned;
  logic [31:0] ld_data;
  logic [31:0] result;

  load_align u_load_align (
    .rdata      (m_mem_rdata),
    .offset     (m_alu_result[1:0]),
    .ld_type    (load_t'(m_ld_type)),
    .data       (ld_data),
    .misaligned (ld_misaligned)
  );

  always_comb begin
    take       = m_valid & ~stall & ~flush;
    misaligned = (m_wb_sel == WB_MEM) & ld_misaligned;

    case (m_wb_sel)
      WB_MEM:  result = ld_data;
      WB_LINK: result = m_link;
      default: result = m_alu_result;
    endcase

    // A misaligned load still retires; only its register write is suppressed.
    we_d         = take & m_reg_write & (m_dest != REG_ZERO) & ~misaligned;
    wa_d         = take ? m_dest : 5'd0;
    wd_d         = take ? result : 32'd0;
    exc_d        = take & misaligned;
    retire_cnt_d = retire_cnt_q + {31'd0, take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      wa_q         <= 5'd0;
      wd_q         <= 32'd0;
      exc_q        <= 1'b0;
      retire_cnt_q <= 32'd0;
    end else begin
      we_q         <= we_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      exc_q        <= exc_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign we           = we_q;
  assign wa           = wa_q;
  assign wd           = wd_q;
  assign fwd_valid    = we_q;
  assign fwd_dest     = wa_q;
  assign fwd_data     = wd_q;
  assign misalign_exc = exc_q;
  assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table of vectors with a scoreboard queue,
// plus hand-written sequences for counter wrap and mid-cycle reset.
module tb_mem_wb_stage;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
  localparam logic [1:0] SA = 2'd0, SM = 2'd1, SL = 2'd2, SR = 2'd3;

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  dest;
    logic [1:0]  sel;
    logic [2:0]  ld;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] link;
    logic        stall;
    logic        flush;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic        exp_exc;
    logic        chk_wd;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        chk_wd;
    logic        exc;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_reg_write = 1'b0;
  logic [4:0]  m_dest = '0;
  logic [1:0]  m_wb_sel = '0;
  logic [2:0]  m_ld_type = '0;
  logic [31:0] m_alu_result = '0;
  logic [31:0] m_mem_rdata = '0;
  logic [31:0] m_link = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        misalign_exc;
  logic [31:0] retire_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_cnt = '0;
  exp_t sb[$];
  vec_t tbl[$];

  mem_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_valid      (m_valid),
    .m_reg_write  (m_reg_write),
    .m_dest       (m_dest),
    .m_wb_sel     (m_wb_sel),
    .m_ld_type    (m_ld_type),
    .m_alu_result (m_alu_result),
    .m_mem_rdata  (m_mem_rdata),
    .m_link       (m_link),
    .stall        (stall),
    .flush        (flush),
    .we           (we),
    .wa           (wa),
    .wd           (wd),
    .fwd_valid    (fwd_valid),
    .fwd_dest     (fwd_dest),
    .fwd_data     (fwd_data),
    .misalign_exc (misalign_exc),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout we=%0b required finish", we);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic rw, input logic [4:0] d,
                              input logic [1:0] s, input logic [2:0] l,
                              input logic [31:0] a, input logic [31:0] r,
                              input logic [31:0] k, input logic st, input logic fl,
                              input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                              input logic ee, input logic cw);
    vec_t x;
    x.valid = v; x.rw = rw; x.dest = d; x.sel = s; x.ld = l; x.alu = a; x.rdata = r;
    x.link = k; x.stall = st; x.flush = fl;
    x.exp_we = ew; x.exp_wa = ea; x.exp_wd = ed; x.exp_exc = ee; x.chk_wd = cw;
    return x;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, SA, LW, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Drive one MEM-stage instruction and queue its expected writeback.
  task automatic drive_push(input vec_t v);
    exp_t e;
    m_valid = v.valid; m_reg_write = v.rw; m_dest = v.dest; m_wb_sel = v.sel;
    m_ld_type = v.ld; m_alu_result = v.alu; m_mem_rdata = v.rdata; m_link = v.link;
    stall = v.stall; flush = v.flush;
    if (v.valid && !v.stall && !v.flush) exp_cnt = exp_cnt + 1;
    e.we = v.exp_we; e.wa = v.exp_wa; e.wd = v.exp_wd; e.chk_wd = v.chk_wd;
    e.exc = v.exp_exc; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic check_pending();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("we", {31'd0, we}, {31'd0, e.we});
      check("wa", {27'd0, wa}, {27'd0, e.wa});
      if (e.chk_wd) check("wd", wd, e.wd);
      check("fwd_valid", {31'd0, fwd_valid}, {31'd0, e.we});
      check("fwd_dest", {27'd0, fwd_dest}, {27'd0, e.wa});
      if (e.chk_wd) check("fwd_data", fwd_data, e.wd);
      check("misalign_exc", {31'd0, misalign_exc}, {31'd0, e.exc});
      check("retire_cnt", retire_cnt, e.cnt);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    check_pending();
    drive_push(v);
  endtask

  initial begin
    //            v rw dst sel ld   alu           rdata         link          st fl
    //            we wa wd                                 exc chk
    tbl.push_back(mk(1, 1, 8, SM, LB, 32'h1001, 32'h11F23344, 0, 0, 0,
                     1, 8, 32'hFFFFFFF2, 0, 1));
    tbl.push_back(mk(1, 1, 8, SM, LBU, 32'h1001, 32'h11F23344, 0, 0, 0,
                     1, 8, 32'h000000F2, 0, 1));
    tbl.push_back(mk(1, 1, 6, SM, LB, 32'h1002, 32'h11F23344, 0, 0, 0,
                     1, 6, 32'h00000033, 0, 1));
    tbl.push_back(mk(1, 1, 13, SM, LB, 32'h1003, 32'h00000080, 0, 0, 0,
                     1, 13, 32'hFFFFFF80, 0, 1));
    tbl.push_back(mk(1, 1, 9, SM, LH, 32'h2002, 32'h1234ABCD, 0, 0, 0,
                     1, 9, 32'hFFFFABCD, 0, 1));
    tbl.push_back(mk(1, 1, 10, SM, LHU, 32'h3000, 32'h8234ABCD, 0, 0, 0,
                     1, 10, 32'h00008234, 0, 1));
    tbl.push_back(mk(1, 1, 12, SM, LW, 32'h4000, 32'hCAFEF00D, 0, 0, 0,
                     1, 12, 32'hCAFEF00D, 0, 1));
    tbl.push_back(mk(1, 1, 11, SM, LW, 32'h4001, 32'hDEADBEEF, 0, 0, 0,
                     0, 11, 32'hDEADBEEF, 1, 1));
    tbl.push_back(mk(1, 1, 14, SM, LH, 32'h5003, 32'h11223344, 0, 0, 0,
                     0, 14, 32'h0, 1, 0));
    tbl.push_back(mk(1, 1, 31, SL, LW, 32'h1234, 32'h0, 32'h00400010, 0, 0,
                     1, 31, 32'h00400010, 0, 1));
    tbl.push_back(mk(1, 1, 0, SA, LW, 32'h55, 32'h0, 0, 0, 0,
                     0, 0, 32'h55, 0, 1));
    tbl.push_back(mk(1, 1, 3, SR, LB, 32'hA5A5, 32'hFFFFFFFF, 32'h9, 0, 0,
                     1, 3, 32'hA5A5, 0, 1));
    tbl.push_back(mk(1, 1, 4, SA, LW, 32'h1, 32'h0, 0, 0, 0,
                     1, 4, 32'h1, 0, 1));
    tbl.push_back(mk(1, 1, 7, SA, LW, 32'h77, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 7, SA, LW, 32'h77, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 7, SM, LW, 32'h3, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 7, SA, LW, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 5, SA, LW, 32'h7, 0, 0, 0, 0, 0, 5, 32'h7, 0, 1));
    tbl.push_back(mk(1, 1, 1, SA, LW, 32'h100, 0, 0, 0, 0, 1, 1, 32'h100, 0, 1));
    tbl.push_back(mk(1, 1, 2, SA, LW, 32'h200, 0, 0, 0, 0, 1, 2, 32'h200, 0, 1));
    tbl.push_back(mk(1, 1, 3, SA, LW, 32'h300, 0, 0, 0, 0, 1, 3, 32'h300, 0, 1));

    // Reset state, with a live instruction on the inputs that must not be captured.
    m_valid = 1'b1; m_reg_write = 1'b1; m_dest = 5'd9; m_alu_result = 32'h1234;
    repeat (3) @(negedge clk);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_wa", {27'd0, wa}, 32'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("rst_exc", {31'd0, misalign_exc}, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    m_valid = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);
    step(idle());
    step(idle());

    // Counter wrap: preload all-ones between edges, then one commit.
    @(negedge clk);
    check_pending();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    #1 check("cnt_preload", retire_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    drive_push(mk(1, 1, 20, SA, LW, 32'hBEEF, 0, 0, 0, 0, 1, 20, 32'hBEEF, 0, 1));
    step(idle());

    // Reset while a write is pending: cleared before the negedge write strobe.
    @(negedge clk);
    check_pending();
    drive_push(mk(1, 1, 21, SA, LW, 32'h77, 0, 0, 0, 0, 1, 21, 32'h77, 0, 1));
    @(posedge clk);
    #1 check("pre_rst_we", {31'd0, we}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_we", {31'd0, we}, 32'd0);
    check("async_rst_wa", {27'd0, wa}, 32'd0);
    check("async_rst_wd", wd, 32'd0);
    check("async_rst_fwd", {31'd0, fwd_valid}, 32'd0);
    check("async_rst_cnt", retire_cnt, 32'd0);
    sb.delete();
    exp_cnt = '0;
    @(negedge clk);
    check("rf_strobe_we", {31'd0, we}, 32'd0);
    #1 rst_n = 1'b1;
    drive_push(mk(1, 1, 22, SM, LBU, 32'h3, 32'h000000AB, 0, 0, 0, 1, 22, 32'hAB, 0, 1));
    step(idle());
    step(idle());
    @(negedge clk);
    check_pending();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
